// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined two's-complement adder/subtractor with valid/ready
// handshake, carry-out, signed-overflow flag and a consumed-result counter.
//
// The carry chain is cut into STAGES chunks of CW = ceil(WIDTH/STAGES) bits.
// Stage k adds chunk k using the carry registered by stage k-1. Upper operand
// chunks ride along until their stage, and finished lower result chunks ride
// along to the output, so a whole result appears on z in one cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   in_valid   operands a/b and mode sub are valid
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   sub        0 = a+b, 1 = a-b
//   out_valid  z/cout/ovf hold a valid result
//   out_ready  consumer takes the result this cycle
//   z          result (WIDTH bits)
//   cout       carry out of bit WIDTH-1 (for sub, 1 = no borrow)
//   ovf        signed overflow
//   count      results consumed since reset, wraps at 2^32
//
// The whole pipeline advances on a single enable (en = !out_valid || out_ready),
// which makes in_ready independent of in_valid and of the operands.

module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf,
   output logic [31:0]      count
);

   // Operands are zero-padded to PW = STAGES*CW bits. Padding bits of both
   // operands are zero, so the carry out of bit WIDTH-1 lands in sum bit WIDTH
   // (or in the final chunk carry when PW == WIDTH).
   localparam int CW = (WIDTH + STAGES - 1) / STAGES;
   localparam int PW = CW * STAGES;

   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("pipe_addsub: WIDTH must be in 2..64");
   end
   if (STAGES < 1 || STAGES > 8 || STAGES > WIDTH) begin : g_bad_stages
      $error("pipe_addsub: STAGES must be in 1..8 and not exceed WIDTH");
   end

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic [PW-1:0]    a_pad;
   logic [PW-1:0]    b_pad;
   logic [CW:0]      chunk;
   logic [PW:0]      out_ext;

   // stage registers
   logic             v_q [STAGES];
   logic [PW-1:0]    a_q [STAGES];
   logic [PW-1:0]    b_q [STAGES];
   logic [PW-1:0]    s_q [STAGES];
   logic             c_q [STAGES];
   logic [1:0]       m_q [STAGES];  // {a msb, b' msb} for the overflow flag

   // stage inputs
   logic             v_d [STAGES];
   logic [PW-1:0]    a_d [STAGES];
   logic [PW-1:0]    b_d [STAGES];
   logic [PW-1:0]    s_d [STAGES];
   logic             c_d [STAGES];
   logic [1:0]       m_d [STAGES];

   // stage outputs (partial sum with this stage's chunk filled in, carry out)
   logic [PW-1:0]    s_n [STAGES];
   logic             c_n [STAGES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   assign b_eff = sub ? ~b : b;
   assign a_pad = PW'(a);
   assign b_pad = PW'(b_eff);

   always_comb begin
      v_d[0] = in_valid;
      a_d[0] = a_pad;
      b_d[0] = b_pad;
      s_d[0] = '0;
      c_d[0] = sub;
      m_d[0] = {a[WIDTH-1], b_eff[WIDTH-1]};
      for (int k = 1; k < STAGES; k++) begin
         v_d[k] = v_q[k-1];
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         s_d[k] = s_q[k-1];
         c_d[k] = c_q[k-1];
         m_d[k] = m_q[k-1];
      end
   end

   always_comb begin
      chunk = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk = {1'b0, a_d[k][k*CW +: CW]}
               + {1'b0, b_d[k][k*CW +: CW]}
               + (CW+1)'(c_d[k]);
         s_n[k]               = s_d[k];
         s_n[k][k*CW +: CW]   = chunk[CW-1:0];
         c_n[k]               = chunk[CW];
      end
   end

   // Bubbles shift exactly like data; on a stall every stage holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            m_q[k] <= 2'b00;
         end
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_n[k];
            c_q[k] <= c_n[k];
            m_q[k] <= m_d[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (out_valid && out_ready) begin
         count <= count + 32'd1;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign z         = s_q[STAGES-1][WIDTH-1:0];
   assign out_ext   = {c_q[STAGES-1], s_q[STAGES-1]};
   assign cout      = out_ext[WIDTH];
   assign ovf       = (m_q[STAGES-1][1] == m_q[STAGES-1][0])
                   && (z[WIDTH-1] != m_q[STAGES-1][1]);

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: a 32-bit/2-stage instance and an 8-bit/1-stage
// instance, directed cases plus randomized traffic with random backpressure,
// checked by a per-instance scoreboard fed from an arithmetic reference model.

module tb_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;

   logic        iv32 = 1'b0, sb32 = 1'b0, or32 = 1'b1;
   logic        ir32, ov32, co32, of32;
   logic [31:0] a32 = '0, b32 = '0, z32, cnt32;

   logic        iv8 = 1'b0, sb8 = 1'b0, or8 = 1'b1;
   logic        ir8, ov8, co8, of8;
   logic [7:0]  a8 = '0, b8 = '0, z8;
   logic [31:0] cnt8;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] z;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t q32[$];
   res_t q8[$];
   int   n32 = 0;
   int   n8  = 0;

   pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut32 (
      .clk(clk), .reset(reset),
      .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .sub(sb32),
      .out_valid(ov32), .out_ready(or32),
      .z(z32), .cout(co32), .ovf(of32), .count(cnt32)
   );

   pipe_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .clk(clk), .reset(reset),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .sub(sb8),
      .out_valid(ov8), .out_ready(or8),
      .z(z8), .cout(co8), .ovf(of8), .count(cnt8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned sum/difference for z and cout,
   // signed sum/difference range test for ovf.
   function automatic res_t model(input int w, input logic [31:0] aa,
                                  input logic [31:0] bb, input logic s);
      res_t   r;
      longint m, ua, ub, sa, sb, ur, sr;
      m  = longint'(1) << w;
      ua = longint'(aa);
      ub = longint'(bb);
      sa = aa[w-1] ? ua - m : ua;
      sb = bb[w-1] ? ub - m : ub;
      if (s) begin
         ur     = ua - ub;
         sr     = sa - sb;
         r.cout = (ua >= ub);
      end else begin
         ur     = ua + ub;
         sr     = sa + sb;
         r.cout = (ur >= m);
      end
      r.z   = 32'(ur & (m - 1));
      r.ovf = (sr < -(m / 2)) || (sr >= (m / 2));
      return r;
   endfunction

   // Scoreboards: sample at the falling edge, between active edges.
   always @(negedge clk) begin
      res_t e;
      if (reset) begin
         q32.delete();
         n32 = 0;
      end else begin
         chk("count32", cnt32, 64'(n32));
         if (ov32 && or32) begin
            chk("sb32_pending", 64'(q32.size() > 0), 1);
            if (q32.size() > 0) begin
               e = q32.pop_front();
               chk("sb32_z", z32, e.z);
               chk("sb32_cout", co32, e.cout);
               chk("sb32_ovf", of32, e.ovf);
            end
            n32++;
         end
         if (iv32 && ir32) q32.push_back(model(32, a32, b32, sb32));
      end
   end

   always @(negedge clk) begin
      res_t e;
      if (reset) begin
         q8.delete();
         n8 = 0;
      end else begin
         chk("count8", cnt8, 64'(n8));
         if (ov8 && or8) begin
            chk("sb8_pending", 64'(q8.size() > 0), 1);
            if (q8.size() > 0) begin
               e = q8.pop_front();
               chk("sb8_z", {24'h0, z8}, e.z);
               chk("sb8_cout", co8, e.cout);
               chk("sb8_ovf", of8, e.ovf);
            end
            n8++;
         end
         if (iv8 && ir8) q8.push_back(model(8, {24'h0, a8}, {24'h0, b8}, sb8));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one transaction and hold it until accepted; returns just after
   // the accepting edge. rnd_or randomizes out_ready every cycle.
   task automatic send32(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                         input bit rnd_or, input string tag);
      bit done;
      done = 1'b0;
      iv32 = 1'b1; a32 = aa; b32 = bb; sb32 = s;
      for (int i = 0; i < 200 && !done; i++) begin
         if (rnd_or) or32 = 1'($urandom_range(0, 1));
         @(negedge clk);
         done = ir32;
         step();
      end
      chk({tag, "_accept"}, done, 1);
      iv32 = 1'b0;
   endtask

   task automatic send8(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                        input bit rnd_or, input string tag);
      bit done;
      done = 1'b0;
      iv8 = 1'b1; a8 = aa; b8 = bb; sb8 = s;
      for (int i = 0; i < 200 && !done; i++) begin
         if (rnd_or) or8 = 1'($urandom_range(0, 1));
         @(negedge clk);
         done = ir8;
         step();
      end
      chk({tag, "_accept"}, done, 1);
      iv8 = 1'b0;
   endtask

   // Single transaction into an empty 2-stage pipe with out_ready high.
   task automatic d32(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                      input logic [31:0] ez, input logic ec, input logic eo,
                      input string tag);
      send32(aa, bb, s, 1'b0, tag);
      @(negedge clk);
      chk({tag, "_early"}, ov32, 0);
      step();
      @(negedge clk);
      chk({tag, "_valid"}, ov32, 1);
      chk({tag, "_z"}, z32, ez);
      chk({tag, "_cout"}, co32, ec);
      chk({tag, "_ovf"}, of32, eo);
      step();
   endtask

   initial begin
      logic [31:0] ba[4];
      logic [31:0] bbv[4];
      logic [31:0] bz[4];
      logic        bo[4];
      logic [31:0] ta, tb;
      res_t        held;

      ba  = '{32'd1, 32'd3, 32'd5, 32'h7FFF_FFFF};
      bbv = '{32'd2, 32'd4, 32'd6, 32'd1};
      bz  = '{32'd3, 32'd7, 32'd11, 32'h8000_0000};
      bo  = '{1'b0, 1'b0, 1'b0, 1'b1};

      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", ov32, 0);
      chk("rst_z", z32, 0);
      chk("rst_cout", co32, 0);
      chk("rst_ovf", of32, 0);
      chk("rst_count", cnt32, 0);
      chk("rst_in_ready", ir32, 1);
      chk("rst_out_valid8", ov8, 0);
      step();

      d32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
      d32(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
      d32(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");

      // back-to-back adds, results on 4 consecutive cycles starting at cycle 2
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            iv32 = 1'b1; a32 = ba[i]; b32 = bbv[i]; sb32 = 1'b0;
         end else begin
            iv32 = 1'b0;
         end
         @(negedge clk);
         if (i < 4) chk("b2b_ready", ir32, 1);
         chk("b2b_valid", ov32, (i >= 2 && i <= 5));
         if (i >= 2 && i <= 5) begin
            chk("b2b_z", z32, bz[i-2]);
            chk("b2b_ovf", of32, bo[i-2]);
         end
         step();
      end
      chk("b2b_count", cnt32, 4);

      // fill, stall 3 cycles, then release
      ta = $urandom; tb = $urandom;
      held = model(32, ta, tb, 1'b1);
      send32(ta, tb, 1'b1, 1'b0, "fill0");
      send32($urandom, $urandom, 1'b0, 1'b0, "fill1");
      or32 = 1'b0;
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; sb32 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", ir32, 0);
         chk("stall_valid", ov32, 1);
         chk("stall_z", z32, held.z);
         chk("stall_cout", co32, held.cout);
         chk("stall_ovf", of32, held.ovf);
         step();
      end
      or32 = 1'b1;
      send32(a32, b32, sb32, 1'b0, "fill2");
      for (int i = 0; i < 3; i++) send32($urandom, $urandom, 1'($urandom), 1'b0, "fill_more");
      for (int i = 0; i < 20 && (q32.size() > 0 || ov32); i++) step();
      chk("stall_drain", 64'(q32.size()), 0);
      chk("stall_count", cnt32, 10);

      // reset with two transactions in flight
      send32($urandom, $urandom, 1'b0, 1'b0, "inflight0");
      send32($urandom, $urandom, 1'b1, 1'b0, "inflight1");
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", ov32, 0);
      chk("midrst_count", cnt32, 0);
      chk("midrst_z", z32, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("midrst_quiet", ov32, 0);
      end
      step();

      // 8-bit single stage
      send8(8'h7F, 8'h01, 1'b0, 1'b0, "w8_ovf");
      @(negedge clk);
      chk("w8_valid", ov8, 1);
      chk("w8_z", z8, 8'h80);
      chk("w8_ovf", of8, 1);
      chk("w8_cout", co8, 0);
      step();

      // randomized traffic with random backpressure on both instances
      fork
         begin
            for (int n = 0; n < 64; n++) begin
               send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "rnd8");
               if ($urandom_range(0, 3) == 0) step();
            end
            or8 = 1'b1;
         end
         begin
            for (int n = 0; n < 64; n++) begin
               send32($urandom, $urandom, 1'($urandom), 1'b1, "rnd32");
               if ($urandom_range(0, 3) == 0) step();
            end
            or32 = 1'b1;
         end
      join
      for (int i = 0; i < 50 && (q32.size() > 0 || q8.size() > 0 || ov32 || ov8); i++) step();
      chk("rnd_drain32", 64'(q32.size()), 0);
      chk("rnd_drain8", 64'(q8.size()), 0);
      chk("rnd_count8", cnt8, 65);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
